// File: rtl/vga_frame_sniffer.sv
// rtl/vga_frame_sniffer.sv - passive VGA stream monitor: coordinate recovery, sync check, per-frame blue box stats
module vga_frame_sniffer #(
    parameter int H_ACTIVE    = 640,
    parameter int H_TOTAL     = 800,
    parameter int HS_START    = 656,
    parameter int V_ACTIVE    = 480,
    parameter int V_TOTAL     = 525,
    parameter int VS_START    = 490,
    parameter int SYNC_ACT    = 0,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic        i_pix_stb,
    input  logic        i_hs,
    input  logic        i_vs,
    input  logic [3:0]  i_r,
    input  logic [3:0]  i_g,
    input  logic [3:0]  i_b,
    output logic [9:0]  o_x,
    output logic [9:0]  o_y,
    output logic        o_active,
    output logic        o_locked,
    output logic        o_sync_err,
    output logic        o_frame_done,
    output logic        o_box_valid,
    output logic [9:0]  o_bx1,
    output logic [9:0]  o_bx2,
    output logic [9:0]  o_by1,
    output logic [9:0]  o_by2,
    output logic [18:0] o_blue_cnt,
    output logic        o_overlap
);
    localparam logic [9:0] HT_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] VT_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] HS_X     = 10'(HS_START);
    localparam logic [9:0] VS_Y     = 10'(VS_START);
    localparam logic [9:0] HA       = 10'(H_ACTIVE);
    localparam logic [9:0] VA       = 10'(V_ACTIVE);
    localparam logic       SYNC_LVL = (SYNC_ACT != 0);
    localparam logic [3:0] LOCK_N   = 4'(LOCK_FRAMES);

    logic        hs_prev, vs_prev, hs_edge, vs_edge;
    logic [9:0]  pred_x, pred_y, cur_x, cur_y;
    logic        mismatch, blue_hit;
    logic [3:0]  clean_cnt, clean_cnt_next;
    logic        locked_next, seen_vs, dirty;
    logic [9:0]  acc_x1, acc_x2, acc_y1, acc_y2;
    logic [9:0]  nxt_x1, nxt_x2, nxt_y1, nxt_y2;
    logic [18:0] acc_cnt, nxt_cnt;
    logic        acc_found, acc_ov, nxt_found, nxt_ov;
    logic        unused_r;

    assign unused_r = ^i_r;
    assign hs_edge  = (i_hs == SYNC_LVL) && (hs_prev != SYNC_LVL);
    assign vs_edge  = (i_vs == SYNC_LVL) && (vs_prev != SYNC_LVL);

    // Free-running prediction, overridden by a sync edge; the row advances when x wraps to 0.
    always_comb begin
        pred_x = (o_x == HT_LAST) ? 10'd0 : o_x + 10'd1;
        cur_x  = hs_edge ? HS_X : pred_x;
        if (cur_x == 10'd0)
            pred_y = (o_y == VT_LAST) ? 10'd0 : o_y + 10'd1;
        else
            pred_y = o_y;
        cur_y    = vs_edge ? VS_Y : pred_y;
        mismatch = (hs_edge && (pred_x != HS_X)) || (vs_edge && (pred_y != VS_Y));
        blue_hit = (cur_x < HA) && (cur_y < VA) && (i_b != 4'd0);
    end

    // A frame is clean only if bounded by two vs edges with no mismatch in between.
    always_comb begin
        clean_cnt_next = clean_cnt;
        locked_next    = o_locked;
        if (mismatch) begin
            clean_cnt_next = 4'd0;
            locked_next    = 1'b0;
        end else if (vs_edge && seen_vs && !dirty) begin
            if (clean_cnt < LOCK_N)
                clean_cnt_next = clean_cnt + 4'd1;
            locked_next = (clean_cnt_next >= LOCK_N);
        end
    end

    // The vs-edge pixel itself starts the new frame's accumulation.
    always_comb begin
        nxt_x1    = vs_edge ? 10'h3FF : acc_x1;
        nxt_x2    = vs_edge ? 10'd0   : acc_x2;
        nxt_y1    = vs_edge ? 10'h3FF : acc_y1;
        nxt_y2    = vs_edge ? 10'd0   : acc_y2;
        nxt_cnt   = vs_edge ? 19'd0   : acc_cnt;
        nxt_found = vs_edge ? 1'b0    : acc_found;
        nxt_ov    = vs_edge ? 1'b0    : acc_ov;
        if (blue_hit) begin
            if (cur_x < nxt_x1) nxt_x1 = cur_x;
            if (cur_x > nxt_x2) nxt_x2 = cur_x;
            if (cur_y < nxt_y1) nxt_y1 = cur_y;
            if (cur_y > nxt_y2) nxt_y2 = cur_y;
            if (nxt_cnt != 19'h7FFFF)
                nxt_cnt = nxt_cnt + 19'd1;
            nxt_found = 1'b1;
            if (i_g != 4'd0)
                nxt_ov = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            o_x          <= HT_LAST;
            o_y          <= VT_LAST;
            hs_prev      <= ~SYNC_LVL;
            vs_prev      <= ~SYNC_LVL;
            o_active     <= 1'b0;
            o_locked     <= 1'b0;
            o_sync_err   <= 1'b0;
            o_frame_done <= 1'b0;
            o_box_valid  <= 1'b0;
            o_bx1        <= 10'd0;
            o_bx2        <= 10'd0;
            o_by1        <= 10'd0;
            o_by2        <= 10'd0;
            o_blue_cnt   <= 19'd0;
            o_overlap    <= 1'b0;
            clean_cnt    <= 4'd0;
            seen_vs      <= 1'b0;
            dirty        <= 1'b0;
            acc_x1       <= 10'h3FF;
            acc_x2       <= 10'd0;
            acc_y1       <= 10'h3FF;
            acc_y2       <= 10'd0;
            acc_cnt      <= 19'd0;
            acc_found    <= 1'b0;
            acc_ov       <= 1'b0;
        end else begin
            o_frame_done <= 1'b0;
            if (i_pix_stb) begin
                hs_prev   <= i_hs;
                vs_prev   <= i_vs;
                o_x       <= cur_x;
                o_y       <= cur_y;
                o_active  <= (cur_x < HA) && (cur_y < VA);
                clean_cnt <= clean_cnt_next;
                o_locked  <= locked_next;
                acc_x1    <= nxt_x1;
                acc_x2    <= nxt_x2;
                acc_y1    <= nxt_y1;
                acc_y2    <= nxt_y2;
                acc_cnt   <= nxt_cnt;
                acc_found <= nxt_found;
                acc_ov    <= nxt_ov;
                if (mismatch)
                    o_sync_err <= 1'b1;
                if (vs_edge) begin
                    seen_vs      <= 1'b1;
                    dirty        <= 1'b0;
                    o_frame_done <= 1'b1;
                    o_box_valid  <= acc_found && locked_next;
                    o_blue_cnt   <= acc_cnt;
                    o_overlap    <= acc_ov;
                    if (acc_found) begin
                        o_bx1 <= acc_x1;
                        o_bx2 <= acc_x2;
                        o_by1 <= acc_y1;
                        o_by2 <= acc_y2;
                    end
                end else if (mismatch) begin
                    dirty <= 1'b1;
                end
            end
        end
    end
endmodule
